// File: rtl/instruction_fetcher.sv
// Instruction fetch unit: answers the scheduler's FETCH handshake from a small
// direct-mapped instruction cache, filling missed lines from program memory.
module instruction_fetcher #(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
  parameter int unsigned CACHE_LINES           = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
);

  localparam int unsigned INDEX_BITS = $clog2(CACHE_LINES);
  localparam int unsigned TAG_BITS   = PROGRAM_MEM_ADDR_BITS - INDEX_BITS;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } state_t;

  state_t state;

  logic [CACHE_LINES-1:0]           line_valid;
  logic [TAG_BITS-1:0]              line_tag  [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] line_data [CACHE_LINES];

  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0]   pc_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  lookup_hit;
  logic                  fill_done;

  assign pc_index   = current_pc[INDEX_BITS-1:0];
  assign pc_tag     = current_pc[PROGRAM_MEM_ADDR_BITS-1:INDEX_BITS];
  // Fills are addressed from the captured request, never the live pc.
  assign fill_index = mem_read_address[INDEX_BITS-1:0];
  assign fill_tag   = mem_read_address[PROGRAM_MEM_ADDR_BITS-1:INDEX_BITS];
  assign lookup_hit = line_valid[pc_index] && (line_tag[pc_index] == pc_tag);
  assign fill_done  = (state == FETCHING) && mem_read_valid && mem_read_ready;

  assign fetcher_state = state;

  // Control FSM, request register, valid bits and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      line_valid       <= '0;
      hit_count        <= 16'd0;
      miss_count       <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (lookup_hit) begin
              instruction <= line_data[pc_index];
              if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
              state <= FETCHED;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= current_pc;
              if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
              state <= FETCHING;
            end
          end
        end
        FETCHING: begin
          if (fill_done) begin
            instruction            <= mem_read_data;
            mem_read_valid         <= 1'b0;
            line_valid[fill_index] <= 1'b1;
            state                  <= FETCHED;
          end
        end
        FETCHED: begin
          if (core_state == CORE_DECODE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Placed last so a coincident flush also discards the line being filled.
      if (flush) line_valid <= '0;
    end
  end

  // Tag/data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (!reset && fill_done) begin
      line_tag[fill_index]  <= fill_tag;
      line_data[fill_index] <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Randomized scoreboard bench for instruction_fetcher against a line-level cache model.
module tb_instruction_fetcher;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned LINES = 8;
  localparam int unsigned IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    core_state;
  logic [AW-1:0] current_pc;
  logic          flush;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [DW-1:0] mem_read_data;
  logic [2:0]    fetcher_state;
  logic [DW-1:0] instruction;
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;

  instruction_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(AW),
    .PROGRAM_MEM_DATA_BITS(DW),
    .CACHE_LINES(LINES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_state(core_state),
    .current_pc(current_pc),
    .flush(flush),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state),
    .instruction(instruction),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: backing memory plus one entry per cache line.
  logic [DW-1:0]    mem [256];
  bit               m_valid [LINES];
  logic [AW-IW-1:0] m_tag   [LINES];
  logic [DW-1:0]    m_data  [LINES];
  int               m_hits, m_misses;

  typedef struct {
    logic [DW-1:0] instr;
    int unsigned   done;
    int            hits;
    int            misses;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
  endtask

  // Monitor: every entry into FETCHED retires one scoreboard entry.
  initial begin
    logic [2:0] prev;
    exp_t e;
    prev = 3'b000;
    forever begin
      @(posedge clk);
      #1;
      if (fetcher_state == 3'b010 && prev != 3'b010) begin
        if (sb.size() == 0) begin
          check("sb_nonempty_on_fetched", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("instruction", 64'(instruction), 64'(e.instr));
          check("done_cycle", 64'(cyc), 64'(e.done));
          check("hit_count", 64'(hit_count), 64'(e.hits));
          check("miss_count", 64'(miss_count), 64'(e.misses));
        end
      end
      prev = fetcher_state;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; core_state = 3'b000; flush = 1'b0; mem_read_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_state", 64'(fetcher_state), 64'd0);
    check("rst_valid", 64'(mem_read_valid), 64'd0);
    check("rst_addr", 64'(mem_read_address), 64'd0);
    check("rst_instr", 64'(instruction), 64'd0);
    check("rst_hits", 64'(hit_count), 64'd0);
    check("rst_misses", 64'(miss_count), 64'd0);
    model_clear();
    m_hits = 0; m_misses = 0;
    sb.delete();
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
  endtask

  // fmode: 0 none, 1 flush with the lookup, 2 flush while waiting, 3 flush with the fill.
  task automatic do_fetch(input logic [AW-1:0] pc, input int w, input int fmode);
    logic [IW-1:0]    idx;
    logic [AW-IW-1:0] tg;
    bit               hit;
    int unsigned      n;
    int               t;
    exp_t             e;
    idx = pc[IW-1:0];
    tg  = pc[AW-1:IW];
    if (fmode == 2 && w == 0) w = 1;
    @(negedge clk);
    hit = m_valid[idx] && (m_tag[idx] == tg);
    core_state = 3'b001; current_pc = pc; flush = (fmode == 1);
    n = cyc + 1;
    if (hit) begin
      if (m_hits < 65535) m_hits++;
      e.instr = m_data[idx]; e.done = n;
    end else begin
      if (m_misses < 65535) m_misses++;
      e.instr = mem[pc]; e.done = n + 1 + int'(w);
    end
    e.hits = m_hits; e.misses = m_misses;
    sb.push_back(e);
    if (fmode == 1) model_clear();
    @(negedge clk);
    flush = 1'b0;
    if (hit) begin
      check("hit_no_request", 64'(mem_read_valid), 64'd0);
      check("hit_state", 64'(fetcher_state), 64'd2);
    end else begin
      check("miss_req_valid", 64'(mem_read_valid), 64'd1);
      check("miss_req_addr", 64'(mem_read_address), 64'(pc));
      if (fmode == 2) begin flush = 1'b1; model_clear(); end
      repeat (w) begin
        mem_read_ready = 1'b0;
        mem_read_data = 16'($urandom);
        @(negedge clk);
        flush = 1'b0;
        check("req_valid_held", 64'(mem_read_valid), 64'd1);
        check("req_addr_held", 64'(mem_read_address), 64'(pc));
      end
      mem_read_ready = 1'b1;
      mem_read_data = mem[pc];
      if (fmode == 3) flush = 1'b1;
      m_valid[idx] = (fmode != 3);
      m_tag[idx] = tg;
      m_data[idx] = mem[pc];
      if (fmode == 3) model_clear();
      @(negedge clk);
      mem_read_ready = 1'b0; flush = 1'b0; mem_read_data = 16'($urandom);
      check("valid_drops_after_ready", 64'(mem_read_valid), 64'd0);
    end
    t = 0;
    while (fetcher_state != 3'b010 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("fetched_reached", 64'(fetcher_state), 64'd2);
    // FETCH held a while longer must not disturb FETCHED.
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("fetched_holds", 64'(fetcher_state), 64'd2);
    end
    core_state = 3'b010;
    @(negedge clk);
    check("decode_to_idle", 64'(fetcher_state), 64'd0);
    core_state = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(3, 7));
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    int w, fm;
    reset = 1'b1; core_state = 3'b000; current_pc = '0; flush = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h05] = 16'hA1B2;
    mem[8'h0D] = 16'h3C4D;
    m_hits = 0; m_misses = 0;
    model_clear();
    do_reset();

    do_fetch(8'h05, 1, 0);
    check("first_instr", 64'(instruction), 64'hA1B2);
    check("first_miss_count", 64'(miss_count), 64'd1);
    do_fetch(8'h05, 0, 0);
    check("refetch_hit_count", 64'(hit_count), 64'd1);
    do_fetch(8'h0D, 1, 0);
    do_fetch(8'h05, 0, 0);
    check("alias_miss_count", 64'(miss_count), 64'd3);
    flush_pulse();
    do_fetch(8'h0D, 0, 0);
    flush_pulse();
    do_fetch(8'h0D, 1, 3);
    check("flush_fill_instr", 64'(instruction), 64'h3C4D);
    do_fetch(8'h0D, 0, 0);
    do_fetch(8'h05, 2, 2);
    do_fetch(8'h05, 0, 1);
    do_fetch(8'h05, 0, 0);

    for (int k = 0; k < 150; k++) begin
      w = $urandom_range(0, 3);
      fm = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
      if ($urandom_range(0, 19) == 0) flush_pulse();
      do_fetch(8'($urandom_range(0, 31)), w, fm);
    end

    // Reset in the middle of an outstanding request, then a stray ready.
    do_reset();
    @(negedge clk);
    core_state = 3'b001; current_pc = 8'h22;
    @(negedge clk);
    core_state = 3'b000;
    check("abort_req_valid", 64'(mem_read_valid), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", 64'(fetcher_state), 64'd0);
    check("abort_valid", 64'(mem_read_valid), 64'd0);
    check("abort_hits", 64'(hit_count), 64'd0);
    check("abort_misses", 64'(miss_count), 64'd0);
    mem_read_ready = 1'b1; mem_read_data = 16'hDEAD;
    @(negedge clk);
    mem_read_ready = 1'b0;
    check("late_ready_state", 64'(fetcher_state), 64'd0);
    check("late_ready_valid", 64'(mem_read_valid), 64'd0);
    check("late_ready_instr", 64'(instruction), 64'd0);
    model_clear();
    m_hits = 0; m_misses = 0;
    sb.delete();
    do_fetch(8'h22, 1, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
